// File: rtl/mem_responder.sv
// Memory-side responder for a single-word load/store port.
// A captured request waits LATENCY cycles, then gets a one-cycle Ack with
// read data (or an error flag). The word array has byte-lane write enables.
module mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Req,
  input  logic        We,
  input  logic [31:0] Addr,
  input  logic [31:0] WData,
  input  logic [3:0]  ByteEn,
  output logic        Ack,
  output logic [31:0] RData,
  output logic        Err,
  output logic        Busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] LAT_M1 = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic accept;
  logic enter_resp;

  logic          we_p0;
  logic [AW-1:0] idx_p0;
  logic [31:0]   wdata_p0;
  logic [3:0]    be_p0;
  logic          err_p0;

  logic          cur_we;
  logic [AW-1:0] cur_idx;
  logic [31:0]   cur_wdata;
  logic [3:0]    cur_be;
  logic          cur_err;

  logic [31:0]   rdata_p1;
  logic          err_p1;

  logic [31:0]   mem [DEPTH];

  // Misaligned or beyond the array: bits above the index only feed this check.
  function automatic logic addr_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:AW+2] != '0);
  endfunction

  // Replace only the enabled byte lanes of a word.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  // Next-state logic; a request is taken only when idle or on the Ack cycle.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    accept     = Req && ((state == IDLE) || (state == RESP));
    enter_resp = 1'b0;
    case (state)
      IDLE, RESP: begin
        if (accept) begin
          if (LATENCY == 0) begin
            state_nxt  = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = LAT_M1;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // With zero latency the response is formed from the live request, otherwise
  // from the captured copy.
  always_comb begin
    cur_we    = accept ? We                : we_p0;
    cur_idx   = accept ? Addr[AW+1:2]      : idx_p0;
    cur_wdata = accept ? WData             : wdata_p0;
    cur_be    = accept ? ByteEn            : be_p0;
    cur_err   = accept ? addr_err(Addr)    : err_p0;
  end

  // State and wait counter.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // p0: request capture.
  always_ff @(posedge Clk) begin
    if (accept) begin
      we_p0    <= We;
      idx_p0   <= Addr[AW+1:2];
      wdata_p0 <= WData;
      be_p0    <= ByteEn;
      err_p0   <= addr_err(Addr);
    end
  end

  // Array write on the edge that enters the response cycle; blocked by reset.
  always_ff @(posedge Clk) begin
    if (enter_resp && !Rst && cur_we && !cur_err) begin
      mem[cur_idx] <= merge_lanes(mem[cur_idx], cur_wdata, cur_be);
    end
  end

  // p1: response data and error; read data holds until the next response.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      rdata_p1 <= 32'd0;
      err_p1   <= 1'b0;
    end else if (enter_resp) begin
      err_p1   <= cur_err;
      rdata_p1 <= (cur_we || cur_err) ? 32'd0 : mem[cur_idx];
    end
  end

  assign Ack   = (state == RESP);
  assign Busy  = (state != IDLE);
  assign Err   = Ack && err_p1;
  assign RData = rdata_p1;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: one LATENCY=2 and one LATENCY=0 instance share the
// initiator stimulus; a transaction-level model predicts both every cycle.
module tb_mem_responder;

  localparam int DEPTH = 256;

  logic        clk;
  logic        rst;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [1:0]  ack, err, busy;
  logic [31:0] rd0, rd1;

  int checks = 0;
  int errors = 0;

  mem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_l2 (
    .Clk(clk), .Rst(rst), .Req(req), .We(we), .Addr(addr), .WData(wdata),
    .ByteEn(be), .Ack(ack[0]), .RData(rd0), .Err(err[0]), .Busy(busy[0]));

  mem_responder #(.DEPTH(DEPTH), .LATENCY(0)) u_l0 (
    .Clk(clk), .Rst(rst), .Req(req), .We(we), .Addr(addr), .WData(wdata),
    .ByteEn(be), .Ack(ack[1]), .RData(rd1), .Err(err[1]), .Busy(busy[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  int          n = 0;
  logic        pend   [2];
  int          r_edge [2];
  logic        t_we   [2];
  logic [31:0] t_a    [2];
  logic [31:0] t_d    [2];
  logic [3:0]  t_b    [2];
  logic        e_ack  [2];
  logic        e_busy [2];
  logic        e_err  [2];
  logic        e_kn   [2];
  logic [31:0] e_rd   [2];
  logic [31:0] mm     [2][DEPTH];
  logic        kn     [2][DEPTH];

  function automatic int lat_of(input int g);
    return (g == 0) ? 2 : 0;
  endfunction

  task automatic model_reset(input int g);
    pend[g] = 1'b0; e_ack[g] = 1'b0; e_busy[g] = 1'b0;
    e_err[g] = 1'b0; e_rd[g] = 32'd0; e_kn[g] = 1'b1;
  endtask

  // Edge n: a transaction whose Ack cycle followed edge n-1 retires; a free
  // responder takes a new request; a transaction due at n responds now.
  task automatic model_step(input int g);
    int idx;
    if (pend[g] && r_edge[g] == n - 1) pend[g] = 1'b0;
    if (!pend[g] && req) begin
      pend[g] = 1'b1; r_edge[g] = n + lat_of(g);
      t_we[g] = we; t_a[g] = addr; t_d[g] = wdata; t_b[g] = be;
    end
    e_ack[g] = 1'b0;
    e_err[g] = 1'b0;
    if (pend[g] && r_edge[g] == n) begin
      e_ack[g] = 1'b1;
      idx = int'(t_a[g][31:2]);
      if (t_a[g][1:0] != 2'b00 || t_a[g] >= 32'(4 * DEPTH)) begin
        e_err[g] = 1'b1; e_rd[g] = 32'd0; e_kn[g] = 1'b1;
      end else if (t_we[g]) begin
        for (int i = 0; i < 4; i++)
          if (t_b[g][i]) mm[g][idx][8*i +: 8] = t_d[g][8*i +: 8];
        if (t_b[g] == 4'hF) kn[g][idx] = 1'b1;
        e_rd[g] = 32'd0; e_kn[g] = 1'b1;
      end else begin
        e_rd[g] = mm[g][idx]; e_kn[g] = kn[g][idx];
      end
    end
    e_busy[g] = pend[g];
  endtask

  initial begin
    for (int g = 0; g < 2; g++) begin
      model_reset(g);
      for (int i = 0; i < DEPTH; i++) begin
        kn[g][i] = 1'b0; mm[g][i] = 32'd0;
      end
    end
  end

  // Model update at each active edge (and immediately on reset).
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int g = 0; g < 2; g++) model_reset(g);
    end else begin
      n++;
      for (int g = 0; g < 2; g++) model_step(g);
    end
  end

  // Compare both instances against the model on every falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      for (int g = 0; g < 2; g++) begin
        chk($sformatf("ack%0d", g), 32'(ack[g]), 32'(e_ack[g]));
        chk($sformatf("busy%0d", g), 32'(busy[g]), 32'(e_busy[g]));
        chk($sformatf("err%0d", g), 32'(err[g]), 32'(e_err[g]));
        if (e_kn[g]) chk($sformatf("rdata%0d", g), (g == 0) ? rd0 : rd1, e_rd[g]);
      end
    end
  end

  // ---------------- initiator ----------------
  // Called on a falling edge; returns on the falling edge inside the L=2 Ack.
  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] b, output logic [31:0] r0,
                      output logic [31:0] r1, output logic e0,
                      output int l0, output int l1);
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    l0 = -1; l1 = -1; r0 = 32'd0; r1 = 32'd0; e0 = 1'b0;
    for (int c = 1; c <= 20 && l0 < 0; c++) begin
      @(negedge clk);
      if (c == 1) req = 1'b0;
      if (ack[1] && l1 < 0) begin l1 = c; r1 = rd1; end
      if (ack[0]) begin l0 = c; r0 = rd0; e0 = err[0]; end
    end
  endtask

  logic [31:0] r0, r1;
  logic        e0;
  int          l0, l1;
  int          k, last, gaps_bad, idle_bad, acks;
  logic [31:0] rds [4];

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0; be = 4'd0;
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rdata0", rd0, 32'd0);
    chk("rst_rdata1", rd1, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Full write then read; latency L+1 sampling edges after capture.
    send(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, r0, r1, e0, l0, l1);
    chk("wr_lat_l2", 32'(l0), 32'd3);
    chk("wr_lat_l0", 32'(l1), 32'd1);
    chk("wr_err", 32'(e0), 32'd0);
    send(1'b0, 32'h10, 32'h0, 4'h0, r0, r1, e0, l0, l1);
    chk("rd_lat_l2", 32'(l0), 32'd3);
    chk("rd_data", r0, 32'hDEADBEEF);
    chk("rd_err", 32'(e0), 32'd0);

    // Partial write, lanes 0 and 2.
    send(1'b1, 32'h10, 32'h11223344, 4'b0101, r0, r1, e0, l0, l1);
    send(1'b0, 32'h10, 32'h0, 4'h0, r0, r1, e0, l0, l1);
    chk("partial", r0, 32'hDE22BE44);

    // Error accesses leave the array untouched.
    send(1'b1, 32'h0, 32'h01234567, 4'hF, r0, r1, e0, l0, l1);
    send(1'b0, 32'h13, 32'h0, 4'h0, r0, r1, e0, l0, l1);
    chk("mis_err", 32'(e0), 32'd1);
    chk("mis_rdata", r0, 32'd0);
    chk("mis_lat", 32'(l0), 32'd3);
    send(1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, r0, r1, e0, l0, l1);
    chk("oor_err", 32'(e0), 32'd1);
    send(1'b0, 32'h0, 32'h0, 4'h0, r0, r1, e0, l0, l1);
    chk("oor_keep", r0, 32'h01234567);

    // Write with no lanes enabled.
    send(1'b1, 32'h0, 32'hFFFFFFFF, 4'h0, r0, r1, e0, l0, l1);
    chk("be0_err", 32'(e0), 32'd0);
    send(1'b0, 32'h0, 32'h0, 4'h0, r0, r1, e0, l0, l1);
    chk("be0_keep", r0, 32'h01234567);

    // Zero-latency instance: read after write.
    send(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, r0, r1, e0, l0, l1);
    send(1'b0, 32'h0, 32'h0, 4'h0, r0, r1, e0, l0, l1);
    chk("l0_lat", 32'(l1), 32'd1);
    chk("l0_rdata", r1, 32'hCAFEF00D);
    chk("l2_rdata", r0, 32'hCAFEF00D);

    // Back-to-back with Req held high.
    req = 1'b1; we = 1'b1; addr = 32'h40; wdata = 32'hA5A5A5A5; be = 4'hF;
    k = 0; last = -1; gaps_bad = 0; idle_bad = 0;
    for (int c = 0; c < 40 && k < 4; c++) begin
      @(negedge clk);
      if (!busy[0]) idle_bad++;
      if (ack[0]) begin
        if (last >= 0 && c - last != 3) gaps_bad++;
        rds[k] = rd0; last = c; k++;
        case (k)
          1: begin we = 1'b0; end
          2: begin we = 1'b1; wdata = 32'h5A5A5A5A; end
          3: begin we = 1'b0; end
          default: req = 1'b0;
        endcase
      end
    end
    chk("b2b_count", 32'(k), 32'd4);
    chk("b2b_gaps", 32'(gaps_bad), 32'd0);
    chk("b2b_busy", 32'(idle_bad), 32'd0);
    chk("b2b_rd1", rds[1], 32'hA5A5A5A5);
    chk("b2b_rd3", rds[3], 32'h5A5A5A5A);
    @(negedge clk);

    // Req pulse during WAIT is ignored.
    req = 1'b1; we = 1'b0; addr = 32'h10; acks = 0; r0 = 32'd0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c == 1) begin we = 1'b1; addr = 32'h44; wdata = 32'h77777777; be = 4'hF; end
      if (c == 2) req = 1'b0;
      if (ack[0]) begin acks++; r0 = rd0; end
    end
    chk("wait_ign_acks", 32'(acks), 32'd1);
    chk("wait_ign_rd", r0, 32'hDE22BE44);

    // Reset during WAIT discards the pending write.
    send(1'b1, 32'h20, 32'hAAAAAAAA, 4'hF, r0, r1, e0, l0, l1);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h12345678; be = 4'hF;
    @(negedge clk);
    req = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_busy", 32'(busy[0]), 32'd0);
    chk("rst_mid_ack", 32'(ack[0]), 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    acks = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (ack[0]) acks++;
    end
    chk("rst_no_ack", 32'(acks), 32'd0);
    send(1'b0, 32'h20, 32'h0, 4'h0, r0, r1, e0, l0, l1);
    chk("rst_keep", r0, 32'hAAAAAAAA);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
